// File: rtl/fpu_mult_arbiter.sv
// Round-robin front end sharing one multi-cycle FPU multiplier between N_REQ requesters.
// Captures the winner's operands, classifies them, strobes the unit and returns a tagged result.
module fpu_mult_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_op_a,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_op_b,
  output logic [N_REQ-1:0]           req_ack,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [BIT_WIDTH-1:0]       rsp_result,
  output logic [3:0]                 rsp_flags,
  output logic                       busy,
  output logic                       fpu_tick_exec,
  output logic [BIT_WIDTH-1:0]       fpu_reg1,
  output logic [BIT_WIDTH-1:0]       fpu_reg2,
  output logic [5:0]                 fpu_reg_params,
  input  logic                       fpu_instr_finished,
  input  logic [BIT_WIDTH-1:0]       fpu_reg_lo,
  input  logic                       fpu_overflow,
  input  logic                       fpu_underflow,
  input  logic                       fpu_invalid_op
);

  localparam int unsigned N_REQ_U = N_REQ;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [BIT_WIDTH-1:0] QNAN = BIT_WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [BIT_WIDTH-1:0] reg1_q, reg1_d;
  logic [BIT_WIDTH-1:0] reg2_q, reg2_d;
  logic [5:0]           params_q, params_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  logic [ID_W-1:0]      winner;
  logic                 found;
  int unsigned          idx;
  logic [BIT_WIDTH-1:0] win_a, win_b;
  logic [2:0]           cls_a, cls_b;
  logic [N_REQ-1:0]     ack;

  // Flush-to-zero classification: {is_inf, is_nan, is_zero}; denormals count as zero.
  function automatic logic [2:0] classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
    classify = {(exp_f == 8'hFF) && (frac_f == '0),
                (exp_f == 8'hFF) && (frac_f != '0),
                (exp_f == 8'h00)};
  endfunction

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N_REQ_U; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ_U;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    win_a = req_op_a[int'(winner)*BIT_WIDTH +: BIT_WIDTH];
    win_b = req_op_b[int'(winner)*BIT_WIDTH +: BIT_WIDTH];
    cls_a = classify(win_a[30:23], win_a[22:0]);
    cls_b = classify(win_b[30:23], win_b[22:0]);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    params_d = params_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    ack      = '0;
    unique case (state_q)
      IDLE: begin
        // Ack is gated by reset so a request seen during reset is never consumed.
        if (found && !rst) begin
          ack[winner] = 1'b1;
          reg1_d      = win_a;
          reg2_d      = win_b;
          params_d    = {cls_b[2], cls_a[2], cls_b[1], cls_a[1], cls_b[0], cls_a[0]};
          id_d        = winner;
          ptr_d       = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done pulse beats a simultaneous timeout.
        if (fpu_instr_finished) begin
          result_d = fpu_reg_lo;
          flags_d  = {1'b0, fpu_invalid_op, fpu_underflow, fpu_overflow};
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = QNAN;
          flags_d  = 4'b1000;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      params_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      params_q <= params_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    req_ack        = ack;
    busy           = (state_q != IDLE) || (|ack);
    fpu_tick_exec  = (state_q == ISSUE);
    rsp_valid      = (state_q == DONE);
    rsp_id         = id_q;
    rsp_result     = result_q;
    rsp_flags      = flags_q;
    fpu_reg1       = reg1_q;
    fpu_reg2       = reg2_q;
    fpu_reg_params = params_q;
  end

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed plus randomized bench for fpu_mult_arbiter with a behavioural multiplier unit model.
module tb_fpu_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_op_a, req_op_b;
  logic [N-1:0]     req_ack;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;
  logic             fpu_tick_exec;
  logic [W-1:0]     fpu_reg1, fpu_reg2;
  logic [5:0]       fpu_reg_params;
  logic             fpu_instr_finished;
  logic [W-1:0]     fpu_reg_lo;
  logic             fpu_overflow, fpu_underflow, fpu_invalid_op;

  logic unit_done, stray_done, unit_hang;
  assign fpu_instr_finished = unit_done | stray_done;

  int errors = 0;
  int checks = 0;
  int tb_ptr;
  int last_id;
  logic [31:0] last_result;
  logic [3:0]  last_flags;
  bit          have_last;

  fpu_mult_arbiter #(.N_REQ(N), .ID_W(2), .BIT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy),
    .fpu_tick_exec(fpu_tick_exec), .fpu_reg1(fpu_reg1), .fpu_reg2(fpu_reg2),
    .fpu_reg_params(fpu_reg_params),
    .fpu_instr_finished(fpu_instr_finished), .fpu_reg_lo(fpu_reg_lo),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_invalid_op(fpu_invalid_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operand kind, answered with plain field tests: 0 zero/denormal, 1 inf, 2 NaN, 3 normal.
  function automatic int kind(input logic [31:0] v);
    int e;
    e = int'(v[30:23]);
    if (e == 0) return 0;
    if (e == 255) return (v[22:0] == 23'd0) ? 1 : 2;
    return 3;
  endfunction

  function automatic logic [5:0] exp_params(input logic [31:0] a, input logic [31:0] b);
    logic [1:0] inf, nan, zero;
    inf  = {kind(b) == 1, kind(a) == 1};
    nan  = {kind(b) == 2, kind(a) == 2};
    zero = {kind(b) == 0, kind(a) == 0};
    return {inf, nan, zero};
  endfunction

  // Behavioural multiplier: exponent arithmetic, opaque mantissa mix; flags {invalid, underflow, overflow}.
  task automatic unit_calc(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [2:0] f);
    int ka, kb, e;
    logic s;
    ka = kind(a); kb = kind(b); s = a[31] ^ b[31];
    f = 3'b000;
    if (ka == 2 || kb == 2 || (ka == 1 && kb == 0) || (ka == 0 && kb == 1)) begin
      r = 32'h7FC0_0000; f = 3'b100;
    end else if (ka == 1 || kb == 1) begin
      r = {s, 8'hFF, 23'd0};
    end else if (ka == 0 || kb == 0) begin
      r = {s, 31'd0};
    end else begin
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f = 3'b001;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f = 3'b010;
      end else begin
        r = {s, 8'(e), a[22:0] ^ b[22:0]};
      end
    end
  endtask

  function automatic logic [31:0] rnd_op(input bit normal_only);
    logic [31:0] v;
    v = $urandom;
    case (normal_only ? 3 : $urandom_range(0, 5))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
    endcase
    return v;
  endfunction

  // Unit model: done during cycle tick+2 for special operands, tick+5 otherwise.
  initial begin
    int unit_cnt;
    logic [31:0] ua, ub, r;
    logic [2:0]  f;
    unit_cnt = 0; unit_done = 1'b0; fpu_reg_lo = '0;
    fpu_overflow = 1'b0; fpu_underflow = 1'b0; fpu_invalid_op = 1'b0;
    ua = '0; ub = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        unit_cnt = 0; unit_done = 1'b0;
      end else begin
        unit_done = 1'b0;
        if (unit_cnt > 0) begin
          unit_cnt--;
          if (unit_cnt == 0) begin
            unit_calc(ua, ub, r, f);
            fpu_reg_lo = r;
            {fpu_invalid_op, fpu_underflow, fpu_overflow} = f;
            unit_done = 1'b1;
          end
        end
        if (fpu_tick_exec && !unit_hang) begin
          ua = fpu_reg1; ub = fpu_reg2;
          unit_cnt = (kind(ua) != 3 || kind(ub) != 3) ? 2 : 5;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op_a[i*W +: W] = a;
    req_op_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic check_all_zero();
    check("rst_ack", 32'(req_ack), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", 32'(rsp_flags), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tick", 32'(fpu_tick_exec), 0);
    check("rst_reg1", fpu_reg1, 0);
    check("rst_reg2", fpu_reg2, 0);
    check("rst_params", 32'(fpu_reg_params), 0);
  endtask

  // Entered at a negedge with this cycle's requests already driven; returns at the rsp_valid negedge.
  task automatic serve_one(input bit keep, input bit expect_to);
    int guard, w, n, lat_exp;
    logic [31:0] a, b, er;
    logic [2:0]  ef;
    logic [3:0]  eflags;
    logic [5:0]  ep;
    bit busy_ok, stable_ok, tick_once;
    if (have_last) begin
      check("rsp_pulse", 32'(rsp_valid), 0);
      check("hold_result", rsp_result, last_result);
      check("hold_flags", 32'(rsp_flags), 32'(last_flags));
    end
    guard = 0;
    while (req_ack == '0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ack_cycle", guard, 0);
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(tb_ptr + k) % N]) w = (tb_ptr + k) % N;
    if (w < 0) begin
      check("no_pending_request", 32'(req_ack), 0);
      return;
    end
    check("ack_onehot", 32'(req_ack), 32'(1) << w);
    check("busy_at_ack", 32'(busy), 1);
    a = req_op_a[w*W +: W];
    b = req_op_b[w*W +: W];
    ep = exp_params(a, b);
    if (expect_to) begin
      er = 32'h7FC0_0000; eflags = 4'b1000; lat_exp = TO + 2;
    end else begin
      unit_calc(a, b, er, ef);
      eflags = {1'b0, ef};
      lat_exp = (kind(a) != 3 || kind(b) != 3) ? 4 : 7;
    end
    @(posedge clk); #1;
    if (!keep) req_valid[w] = 1'b0;
    @(negedge clk);
    n = 1;
    check("tick_exec", 32'(fpu_tick_exec), 1);
    check("fpu_reg1", fpu_reg1, a);
    check("fpu_reg2", fpu_reg2, b);
    check("fpu_params", 32'(fpu_reg_params), 32'(ep));
    busy_ok = busy; stable_ok = 1'b1; tick_once = 1'b1;
    while (!rsp_valid && n < TO + 10) begin
      @(negedge clk);
      n++;
      busy_ok &= busy;
      if (fpu_reg1 !== a || fpu_reg2 !== b || fpu_reg_params !== ep) stable_ok = 1'b0;
      if (fpu_tick_exec) tick_once = 1'b0;
    end
    check("rsp_latency", n, lat_exp);
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), w);
    check("rsp_result", rsp_result, er);
    check("rsp_flags", 32'(rsp_flags), 32'(eflags));
    check("busy_span", 32'(busy_ok), 1);
    check("operands_stable", 32'(stable_ok), 1);
    check("tick_single", 32'(tick_once), 1);
    tb_ptr = (w + 1) % N;
    last_id = w;
    last_result = er;
    last_flags = eflags;
    have_last = 1'b1;
  endtask

  task automatic go(input bit keep, input bit expect_to);
    @(negedge clk);
    serve_one(keep, expect_to);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op_a = '0; req_op_b = '0;
    stray_done = 1'b0; unit_hang = 1'b0;
    tb_ptr = 0; last_id = 0; have_last = 1'b0; last_result = '0; last_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero();
    @(posedge clk); #1;
    rst = 1'b0;

    set_req(0, 32'h4000_0000, 32'h4040_0000);
    go(0, 0);
    check("mul_2x3", rsp_result, 32'h40C0_0000);

    @(posedge clk); #1;
    set_req(1, 32'h7F00_0000, 32'h7F00_0000);
    go(0, 0);
    check("overflow_flag", 32'(rsp_flags), 32'b0001);

    @(posedge clk); #1;
    set_req(2, 32'h0000_0000, 32'h7F80_0000);
    go(0, 0);

    @(posedge clk); #1;
    set_req(3, 32'h3F80_0000, 32'h3F80_0000);
    go(0, 0);

    // All four requesters held high: service order must rotate 0,1,2,3,0.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, rnd_op(1), rnd_op(1));
    for (int k = 0; k < 5; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      go(1, 0);
      check("rr_order", last_id, k % N);
    end
    @(posedge clk); #1;
    req_valid = '0;

    @(posedge clk); #1;
    unit_hang = 1'b1;
    set_req(2, rnd_op(1), rnd_op(1));
    go(0, 1);
    @(posedge clk); #1;
    unit_hang = 1'b0;
    set_req(1, rnd_op(1), rnd_op(1));
    go(0, 0);

    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stray_no_rsp", 32'(rsp_valid), 0);
      check("stray_idle", 32'(busy), 0);
    end

    // Reset in the middle of WAIT must abandon the transaction.
    @(posedge clk); #1;
    set_req(0, rnd_op(1), rnd_op(1));
    @(negedge clk);
    check("pre_rst_ack", 32'(req_ack), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    tb_ptr = 0; have_last = 1'b0;
    set_req(1, rnd_op(1), rnd_op(1));
    go(0, 0);
    check("post_rst_winner", last_id, 1);

    for (int t = 0; t < 24; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_op(0), rnd_op(0));
      if (req_valid == '0) set_req(int'($urandom_range(0, N - 1)), rnd_op(0), rnd_op(0));
      go(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
